contador_multicanal: RTL and testbench
======================================

// Module: contador_multicanal
// PURPOSE
//  Parametrised per-channel pop counter; successor to the fixed 4-channel, 5-bit contador.
//  Counts pop strobes from NUM_CH FIFOs and returns one channel's count on a req/idx read port while idle.
//  Adds saturate/wrap mode, clear-on-read, global clear, sticky overflow flags and index-error reporting.
//  Sits beside the FIFO bank and feeds the status/readout logic.
// PARAMETERS
//  NUM_CH         4   number of counted channels (1..16)
//  CNT_W          5   counter width per channel, in bits
//  IDX_W          2   width of idx; must satisfy 2**IDX_W >= NUM_CH
//  SATURATE       0   0 = wrap to 0 at max, 1 = hold at 2**CNT_W-1
//  CLEAR_ON_READ  0   1 = the channel read is zeroed on the read cycle
// PORTS
//  clk             in   1        single clock; all state updates on posedge
//  reset           in   1        synchronous, active-low (0 = reset)
//  pop             in   NUM_CH   pop[i]=1: count one pop on channel i this cycle
//  req             in   1        read request
//  idx             in   IDX_W    channel selected for the read
//  IDLE            in   1        read window; a read happens only if req & IDLE
//  clear_all       in   1        zeroes all counters and ovf flags
//  valid_contador  out  1        1-cycle pulse: contador_out is valid
//  contador_out    out  CNT_W    registered count of the channel read
//  ovf             out  NUM_CH   sticky: channel i wrapped or hit saturation
//  idx_err         out  1        1-cycle pulse with valid_contador: idx >= NUM_CH
// BEHAVIOUR
//  - Reset (reset==0 at posedge): all counters, ovf, valid_contador, contador_out, idx_err = 0. Reset wins over every other input.
//  - Counting: pop[i] at posedge -> cnt[i]+1. Counting is independent of IDLE and req. Channels update in parallel; any mix of pops is allowed.
//  - Max value: at cnt==2**CNT_W-1 with pop: wrap to 0 (SATURATE=0), else hold. In both cases ovf[i] <= 1; it stays set until clear_all or reset.
//  - Read: req & IDLE sampled at posedge N -> at N+1 valid_contador=1 and contador_out=cnt[idx], using the value before any pop counted at N (1-cycle latency).
//  - No read: valid_contador=0, idx_err=0, contador_out holds its last value.
//  - Back-to-back reads allowed (one per cycle, each with a 1-cycle latency).
//  - idx >= NUM_CH on a read: valid_contador=1, contador_out=0, idx_err=1; no counter changes.
//  - CLEAR_ON_READ=1: the read channel becomes 0, or 1 if pop[idx] is also set that cycle, so no pop is lost. Its ovf is cleared.
//  - clear_all: all counters 0 and ovf 0; a simultaneous pop is dropped. A simultaneous read returns the pre-clear value.
//  - req while IDLE=0: ignored; no queuing.
// STRUCTURE
//  - Package contador_pkg:
//    - mode localparams MODE_WRAP=0, MODE_SAT=1
//    - function cnt_next(cnt, pop, sat, clr) and the max-value constant helper.
//  - Sub-module contador_canal (one channel: counter + ovf flag), instantiated NUM_CH times via generate.
//  - Top level holds the read mux, output registers and the idx range check.
// TESTING
//  - Reset: hold reset=0 for 3 clk with pop=4'hF -> all outputs 0. After release, 2 cycles of pop=4'b0010 then read idx=1 -> contador_out=2, valid for 1 cycle.
//  - Wrap (CNT_W=5, SATURATE=0): 33 pops on ch2 -> read gives 1 and ovf[2]=1. clear_all -> ovf=0, and a read gives 0.
//  - Saturate (SATURATE=1): 40 pops on ch0 -> read gives 31 and ovf[0]=1.
//  - Read gating: req=1, IDLE=0 -> valid_contador stays 0. Then req=1, IDLE=1 with idx 0,1,2,3 on consecutive cycles -> 4 consecutive valid pulses, each one cycle after its request, with matching counts.
//  - CLEAR_ON_READ=1: ch3=5, read idx=3 with pop[3]=1 -> output 5; next read of ch3 with no pop -> 1.
//  - NUM_CH=3, IDX_W=2: read idx=3 -> valid_contador=1, idx_err=1, contador_out=0, counters unchanged. Reset mid-read -> valid_contador=0 on the next cycle.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared definitions for the multichannel pop counter.
// Contents:
//   MODE_WRAP / MODE_SAT  values for the SATURATE parameter
//   cnt_max()             all-ones value of a counter of the given width
//   cnt_next()            next count of one channel. The function works on
//                         32-bit values, and callers zero-extend and truncate.
package contador_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Largest value a w-bit counter can hold (1 <= w <= 32).
  function automatic logic [31:0] cnt_max(input int w);
    return 32'hFFFF_FFFF >> (32 - w);
  endfunction

  // Next count for one channel.
  //   clr : restart from zero before counting (clear-on-read).
  //         A pop in the same cycle then counts as the first pop.
  //   sat : hold at max instead of wrapping to zero.
  function automatic logic [31:0] cnt_next(input logic [31:0] cnt,
                                           input logic        pop,
                                           input logic        sat,
                                           input logic        clr,
                                           input logic [31:0] max);
    logic [31:0] base;
    base = clr ? 32'd0 : cnt;
    if (!pop)
      return base;
    if (base == max)
      return sat ? max : 32'd0;
    return base + 32'd1;
  endfunction

endpackage

// File: rtl/contador_canal.sv
// One counted channel: the pop counter plus its sticky overflow flag.
// Ports:
//   clk        clock; state updates on posedge
//   reset      synchronous, active-low
//   pop_i      count one pop this cycle
//   clr_all_i  zero the counter and the flag; a simultaneous pop is dropped
//   rd_clr_i   clear-on-read of this channel; a simultaneous pop is kept
//   cnt_o      current count
//   ovf_o      sticky: the counter wrapped or hit saturation
module contador_canal
  import contador_pkg::*;
#(
  parameter int CNT_W    = 5,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pop_i,
  input  logic             clr_all_i,
  input  logic             rd_clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  localparam logic [31:0] MAX = cnt_max(CNT_W);
  localparam logic        SAT = (SATURATE == MODE_SAT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [31:0]      cnt_ext;
  logic [31:0]      cnt_nxt;
  logic             unused_nxt;

  always_comb begin
    cnt_ext              = '0;
    cnt_ext[CNT_W-1:0]   = cnt_q;
    cnt_nxt              = cnt_next(cnt_ext, pop_i, SAT, rd_clr_i, MAX);
    cnt_d                = cnt_nxt[CNT_W-1:0];
    ovf_d                = ovf_q;
    if (clr_all_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (rd_clr_i) begin
      // After clear-on-read the count restarts, so overflow history goes too.
      ovf_d = 1'b0;
    end else if (pop_i && (cnt_ext == MAX)) begin
      ovf_d = 1'b1;
    end
  end

  // Bits of cnt_nxt above CNT_W are always zero.
  assign unused_nxt = ^cnt_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/contador_multicanal.sv
// Parametrised per-channel pop counter with a registered req/idx read port.
// Ports:
//   clk             clock; all state updates on posedge
//   reset           synchronous, active-low (0 = reset)
//   pop[NUM_CH]     count one pop on each flagged channel
//   req, idx, IDLE  a read of channel idx happens when req & IDLE
//   clear_all       zero all counters and ovf flags
//   valid_contador  1-cycle pulse, one cycle after the read
//   contador_out    count of the channel read, taken before that cycle's pop;
//                   holds its value between reads
//   ovf[NUM_CH]     sticky overflow flag per channel
//   idx_err         pulses with valid_contador when idx >= NUM_CH
module contador_multicanal
  import contador_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int CNT_W         = 5,
  parameter int IDX_W         = 2,
  parameter int SATURATE      = MODE_WRAP,
  parameter int CLEAR_ON_READ = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] pop,
  input  logic              req,
  input  logic [IDX_W-1:0]  idx,
  input  logic              IDLE,
  input  logic              clear_all,
  output logic              valid_contador,
  output logic [CNT_W-1:0]  contador_out,
  output logic [NUM_CH-1:0] ovf,
  output logic              idx_err
);

  localparam logic [IDX_W:0] NUM_CH_L = (IDX_W + 1)'(NUM_CH);

  logic              rd;
  logic              idx_ok;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] rd_clr;
  logic [NUM_CH-1:0] ovf_w;
  logic [CNT_W-1:0]  cnt_w [NUM_CH];
  logic [CNT_W-1:0]  rd_val;

  logic              valid_q, valid_d;
  logic              idx_err_q, idx_err_d;
  logic [CNT_W-1:0]  out_q, out_d;

  // Read decode. An out-of-range idx matches no channel, so the read
  // returns 0 and no counter is touched.
  always_comb begin
    rd     = req & IDLE;
    idx_ok = ({1'b0, idx} < NUM_CH_L);
    sel    = '0;
    rd_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == i[IDX_W-1:0]) begin
        sel[i] = 1'b1;
        rd_val = cnt_w[i];
      end
    end
    rd_clr = ((CLEAR_ON_READ != 0) && rd) ? sel : '0;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_canal
    contador_canal #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_canal (
      .clk       (clk),
      .reset     (reset),
      .pop_i     (pop[g]),
      .clr_all_i (clear_all),
      .rd_clr_i  (rd_clr[g]),
      .cnt_o     (cnt_w[g]),
      .ovf_o     (ovf_w[g])
    );
  end

  always_comb begin
    valid_d   = rd;
    idx_err_d = rd & ~idx_ok;
    out_d     = rd ? rd_val : out_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      idx_err_q <= 1'b0;
      out_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      idx_err_q <= idx_err_d;
      out_q     <= out_d;
    end
  end

  assign valid_contador = valid_q;
  assign idx_err        = idx_err_q;
  assign contador_out   = out_q;
  assign ovf            = ovf_w;

endmodule

// File: tb/tb_contador_multicanal.sv
// Directed bench for contador_multicanal. It uses four instances:
//   u_wrap  4 channels, wrap mode
//   u_sat   4 channels, saturate mode
//   u_cor   4 channels, clear-on-read
//   u_c3    3 channels with a 2-bit idx
// All instances share the clock, reset, idx and IDLE.
// Inputs change 1 time unit after the posedge, and outputs are sampled there too.
module tb_contador_multicanal;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] idx;
  logic       idle;
  logic       clr_w;
  logic       zero;

  logic [3:0] pop_w, pop_s, pop_c;
  logic [2:0] pop_3;
  logic       req_w, req_s, req_c, req_3;

  logic       vld_w, vld_s, vld_c, vld_3;
  logic       err_w, err_s, err_c, err_3;
  logic [4:0] cout_w, cout_s, cout_c, cout_3;
  logic [3:0] ovf_w, ovf_s, ovf_c;
  logic [2:0] ovf_3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  contador_multicanal #(.NUM_CH(4), .CNT_W(5), .IDX_W(2), .SATURATE(0), .CLEAR_ON_READ(0)) u_wrap (
    .clk(clk), .reset(reset), .pop(pop_w), .req(req_w), .idx(idx), .IDLE(idle),
    .clear_all(clr_w), .valid_contador(vld_w), .contador_out(cout_w), .ovf(ovf_w), .idx_err(err_w));

  contador_multicanal #(.NUM_CH(4), .CNT_W(5), .IDX_W(2), .SATURATE(1), .CLEAR_ON_READ(0)) u_sat (
    .clk(clk), .reset(reset), .pop(pop_s), .req(req_s), .idx(idx), .IDLE(idle),
    .clear_all(zero), .valid_contador(vld_s), .contador_out(cout_s), .ovf(ovf_s), .idx_err(err_s));

  contador_multicanal #(.NUM_CH(4), .CNT_W(5), .IDX_W(2), .SATURATE(0), .CLEAR_ON_READ(1)) u_cor (
    .clk(clk), .reset(reset), .pop(pop_c), .req(req_c), .idx(idx), .IDLE(idle),
    .clear_all(zero), .valid_contador(vld_c), .contador_out(cout_c), .ovf(ovf_c), .idx_err(err_c));

  contador_multicanal #(.NUM_CH(3), .CNT_W(5), .IDX_W(2), .SATURATE(0), .CLEAR_ON_READ(0)) u_c3 (
    .clk(clk), .reset(reset), .pop(pop_3), .req(req_3), .idx(idx), .IDLE(idle),
    .clear_all(zero), .valid_contador(vld_3), .contador_out(cout_3), .ovf(ovf_3), .idx_err(err_3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    zero  = 1'b0;
    clr_w = 1'b0;
    idx   = 2'd0;
    idle  = 1'b1;

    // Reset held for 3 cycles while every input is active.
    reset = 1'b0;
    pop_w = 4'hF; pop_s = 4'hF; pop_c = 4'hF; pop_3 = 3'h7;
    req_w = 1'b1; req_s = 1'b1; req_c = 1'b1; req_3 = 1'b1;
    repeat (3) tick();
    chk("rst_vld_w",  32'(vld_w),  32'd0);
    chk("rst_cout_w", 32'(cout_w), 32'd0);
    chk("rst_ovf_w",  32'(ovf_w),  32'd0);
    chk("rst_err_w",  32'(err_w),  32'd0);
    chk("rst_vld_s",  32'(vld_s),  32'd0);
    chk("rst_err_s",  32'(err_s),  32'd0);
    chk("rst_vld_c",  32'(vld_c),  32'd0);
    chk("rst_err_c",  32'(err_c),  32'd0);
    chk("rst_vld_3",  32'(vld_3),  32'd0);
    chk("rst_err_3",  32'(err_3),  32'd0);

    reset = 1'b1;
    pop_w = 4'h0; pop_s = 4'h0; pop_c = 4'h0; pop_3 = 3'h0;
    req_w = 1'b0; req_s = 1'b0; req_c = 1'b0; req_3 = 1'b0;

    // u_wrap: two pops on ch1, then read ch1.
    pop_w = 4'b0010;
    repeat (2) tick();
    pop_w = 4'b0000; req_w = 1'b1; idx = 2'd1;
    tick();
    chk("first_vld",  32'(vld_w),  32'd1);
    chk("first_cout", 32'(cout_w), 32'd2);
    chk("first_err",  32'(err_w),  32'd0);
    req_w = 1'b0;
    tick();
    chk("first_vld_pulse", 32'(vld_w),  32'd0);
    chk("first_cout_hold", 32'(cout_w), 32'd2);

    // A request outside the IDLE window is ignored.
    req_w = 1'b1; idle = 1'b0;
    tick();
    chk("gate_vld_a", 32'(vld_w), 32'd0);
    tick();
    chk("gate_vld_b", 32'(vld_w), 32'd0);
    req_w = 1'b0; idle = 1'b1;
    tick();
    chk("gate_no_queue", 32'(vld_w), 32'd0);

    // Wrap: 31 pops reach max without overflow. On the 32nd pop, read ch2
    // in the same cycle, so the read returns the value before that pop.
    pop_w = 4'b0100;
    repeat (31) tick();
    chk("wrap_ovf_pre", 32'(ovf_w), 32'd0);
    req_w = 1'b1; idx = 2'd2;
    tick();
    chk("wrap_rd_max",  32'(cout_w), 32'd31);
    chk("wrap_ovf_set", 32'(ovf_w),  32'b0100);
    req_w = 1'b0;
    tick();
    pop_w = 4'b0000; req_w = 1'b1; idx = 2'd2;
    tick();
    chk("wrap_rd_33", 32'(cout_w), 32'd1);
    chk("wrap_ovf",   32'(ovf_w),  32'b0100);
    req_w = 1'b0;

    // Back-to-back reads of all channels: ch0=1, ch1=2, ch2=1, ch3=3.
    pop_w = 4'b1001;
    tick();
    pop_w = 4'b1000;
    repeat (2) tick();
    pop_w = 4'b0000; req_w = 1'b1; idx = 2'd0;
    tick();
    chk("b2b_vld0", 32'(vld_w),  32'd1);
    chk("b2b_rd0",  32'(cout_w), 32'd1);
    idx = 2'd1;
    tick();
    chk("b2b_vld1", 32'(vld_w),  32'd1);
    chk("b2b_rd1",  32'(cout_w), 32'd2);
    idx = 2'd2;
    tick();
    chk("b2b_vld2", 32'(vld_w),  32'd1);
    chk("b2b_rd2",  32'(cout_w), 32'd1);
    idx = 2'd3; pop_w = 4'b1000;
    tick();
    chk("b2b_vld3", 32'(vld_w),  32'd1);
    chk("b2b_rd3",  32'(cout_w), 32'd3);
    req_w = 1'b0; pop_w = 4'b0000;
    tick();
    chk("b2b_end_vld",  32'(vld_w),  32'd0);
    chk("b2b_end_hold", 32'(cout_w), 32'd3);

    // clear_all with a simultaneous read (returns 4) and pops (dropped).
    clr_w = 1'b1; req_w = 1'b1; idx = 2'd3; pop_w = 4'b1111;
    tick();
    chk("clr_rd_pre", 32'(cout_w), 32'd4);
    chk("clr_ovf",    32'(ovf_w),  32'd0);
    clr_w = 1'b0; pop_w = 4'b0000;
    tick();
    chk("clr_rd_ch3", 32'(cout_w), 32'd0);
    idx = 2'd0;
    tick();
    chk("clr_rd_ch0", 32'(cout_w), 32'd0);
    req_w = 1'b0;

    // u_sat: 40 pops on ch0 hold at 31. The flag sets on the 32nd pop.
    pop_s = 4'b0001;
    repeat (31) tick();
    chk("sat_ovf_pre", 32'(ovf_s), 32'd0);
    tick();
    chk("sat_ovf_set", 32'(ovf_s), 32'b0001);
    repeat (8) tick();
    pop_s = 4'b0000; req_s = 1'b1; idx = 2'd0;
    tick();
    chk("sat_vld", 32'(vld_s),  32'd1);
    chk("sat_rd",  32'(cout_s), 32'd31);
    chk("sat_err", 32'(err_s),  32'd0);
    req_s = 1'b0;

    // u_cor: ch0=ch3=5. Read ch3 with a pop (returns 5, restarts at 1).
    pop_c = 4'b1001;
    repeat (5) tick();
    pop_c = 4'b1000; req_c = 1'b1; idx = 2'd3;
    tick();
    chk("cor_rd5", 32'(cout_c), 32'd5);
    pop_c = 4'b0000;
    tick();
    chk("cor_rd1", 32'(cout_c), 32'd1);
    idx = 2'd0;
    tick();
    chk("cor_rd_ch0", 32'(cout_c), 32'd5);
    tick();
    chk("cor_rd_ch0_cleared", 32'(cout_c), 32'd0);
    chk("cor_ovf",            32'(ovf_c),  32'd0);
    req_c = 1'b0;

    // u_c3: ch0=ch1=2. An out-of-range idx reports an error and reads 0.
    pop_3 = 3'b011;
    repeat (2) tick();
    pop_3 = 3'b000; req_3 = 1'b1; idx = 2'd1;
    tick();
    chk("c3_rd1",  32'(cout_3), 32'd2);
    chk("c3_err0", 32'(err_3),  32'd0);
    idx = 2'd3;
    tick();
    chk("c3_bad_vld",  32'(vld_3),  32'd1);
    chk("c3_bad_err",  32'(err_3),  32'd1);
    chk("c3_bad_cout", 32'(cout_3), 32'd0);
    idx = 2'd1;
    tick();
    chk("c3_after_cout", 32'(cout_3), 32'd2);
    chk("c3_after_err",  32'(err_3),  32'd0);
    chk("c3_ovf",        32'(ovf_3),  32'd0);

    // Reset at the same edge as a read request wins.
    idx = 2'd0; reset = 1'b0;
    tick();
    chk("c3_rst_vld",  32'(vld_3),  32'd0);
    chk("c3_rst_cout", 32'(cout_3), 32'd0);
    chk("c3_rst_err",  32'(err_3),  32'd0);
    reset = 1'b1; req_3 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
